// File: rtl/cla_pkg.sv
// Shared constants and the group generate/propagate equation for the
// carry-lookahead adder and any other lookahead user.
package cla_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_GROUPSIZE = 4;
  localparam int NGROUPS       = DEF_WIDTH / DEF_GROUPSIZE;
  localparam int GS_MAX        = 8;

  // gp_vec = {g[GS_MAX-1:0], p[GS_MAX-1:0]}; only the low gs bits of each half count.
  function automatic logic [1:0] group_gp(input logic [2*GS_MAX-1:0] gp_vec, input int gs);
    logic gg;
    logic gprop;
    gg    = 1'b0;
    gprop = 1'b1;
    for (int i = 0; i < GS_MAX; i++) begin
      if (i < gs) begin
        gg    = gp_vec[GS_MAX+i] | (gp_vec[i] & gg);
        gprop = gprop & gp_vec[i];
      end
    end
    return {gg, gprop};
  endfunction

endpackage

// File: rtl/cla_adder_pipe_gp.sv
// Combinational per-group generate/propagate: bit g/p plus the group {G,P}.
module cla_group_gp
  import cla_pkg::*;
#(
  parameter int GROUPSIZE = DEF_GROUPSIZE
) (
  input  logic [GROUPSIZE-1:0] a,
  input  logic [GROUPSIZE-1:0] b_eff,
  output logic [GROUPSIZE-1:0] g,
  output logic [GROUPSIZE-1:0] p,
  output logic [1:0]           gp
);

  logic [2*GS_MAX-1:0] gp_vec;

  assign g = a & b_eff;
  assign p = a ^ b_eff;

  always_comb begin
    gp_vec                     = '0;
    gp_vec[GS_MAX +: GROUPSIZE] = g;
    gp_vec[0 +: GROUPSIZE]      = p;
    gp                         = group_gp(gp_vec, GROUPSIZE);
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor: stage 1 registers
// bit and group g/p, stage 2 resolves group carries and registers sum and flags.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int GROUPSIZE = DEF_GROUPSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NG = WIDTH / GROUPSIZE;

  generate
    if ((WIDTH % GROUPSIZE) != 0 ||
        !(GROUPSIZE == 1 || GROUPSIZE == 2 || GROUPSIZE == 4 || GROUPSIZE == 8)) begin : g_bad_cfg
      $fatal(1, "cla_adder_pipe: illegal WIDTH/GROUPSIZE combination");
    end
  endgenerate

  logic [WIDTH-1:0] b_eff;
  logic             c0_in;
  logic [WIDTH-1:0] bit_g;
  logic [WIDTH-1:0] bit_p;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;

  assign b_eff = in_sub ? ~in_b : in_b;
  assign c0_in = in_sub | in_cin;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      logic [1:0] gp;
      cla_group_gp #(.GROUPSIZE(GROUPSIZE)) u_gp (
        .a     (in_a[gi*GROUPSIZE +: GROUPSIZE]),
        .b_eff (b_eff[gi*GROUPSIZE +: GROUPSIZE]),
        .g     (bit_g[gi*GROUPSIZE +: GROUPSIZE]),
        .p     (bit_p[gi*GROUPSIZE +: GROUPSIZE]),
        .gp    (gp)
      );
      assign grp_g[gi] = gp[1];
      assign grp_p[gi] = gp[0];
    end
  endgenerate

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_g_reg;
  logic [WIDTH-1:0] s1_p_reg;
  logic [NG-1:0]    s1_gg_reg;
  logic [NG-1:0]    s1_gp_reg;
  logic             s1_c0_reg;
  logic             s1_a_msb_reg;
  logic             s1_b_msb_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_sum_reg;
  logic             out_cout_reg;
  logic             out_ovf_reg;
  logic             out_zero_reg;

  logic s2_adv;
  logic in_fire;

  // Stage 1 may refill in the same cycle it hands its content to stage 2.
  assign s2_adv   = s1_valid_reg & (~out_valid_reg | out_ready);
  assign in_ready = ~s1_valid_reg | s2_adv;
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_g_reg     <= '0;
      s1_p_reg     <= '0;
      s1_gg_reg    <= '0;
      s1_gp_reg    <= '0;
      s1_c0_reg    <= 1'b0;
      s1_a_msb_reg <= 1'b0;
      s1_b_msb_reg <= 1'b0;
    end else if (in_fire) begin
      s1_valid_reg <= 1'b1;
      s1_g_reg     <= bit_g;
      s1_p_reg     <= bit_p;
      s1_gg_reg    <= grp_g;
      s1_gp_reg    <= grp_p;
      s1_c0_reg    <= c0_in;
      s1_a_msb_reg <= in_a[WIDTH-1];
      s1_b_msb_reg <= b_eff[WIDTH-1];
    end else if (s2_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  logic [NG:0]      grp_c;
  logic             carry;
  logic [WIDTH-1:0] sum_next;
  logic             cout_next;
  logic             ovf_next;
  logic             zero_next;

  always_comb begin
    grp_c    = '0;
    grp_c[0] = s1_c0_reg;
    for (int k = 0; k < NG; k++) begin
      grp_c[k+1] = s1_gg_reg[k] | (s1_gp_reg[k] & grp_c[k]);
    end
    // Each group ripples locally from its lookahead carry-in.
    carry    = 1'b0;
    sum_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i % GROUPSIZE) == 0) carry = grp_c[i / GROUPSIZE];
      sum_next[i] = s1_p_reg[i] ^ carry;
      carry       = s1_g_reg[i] | (s1_p_reg[i] & carry);
    end
    cout_next = grp_c[NG];
    ovf_next  = (s1_a_msb_reg == s1_b_msb_reg) & (sum_next[WIDTH-1] != s1_a_msb_reg);
    zero_next = ~|sum_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_cout_reg  <= 1'b0;
      out_ovf_reg   <= 1'b0;
      out_zero_reg  <= 1'b0;
    end else if (s2_adv) begin
      out_valid_reg <= 1'b1;
      out_sum_reg   <= sum_next;
      out_cout_reg  <= cout_next;
      out_ovf_reg   <= ovf_next;
      out_zero_reg  <= zero_next;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_sum   = out_sum_reg;
  assign out_cout  = out_cout_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_zero  = out_zero_reg;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Scoreboard bench for cla_adder_pipe: directed corner cases, backpressure,
// mid-flight reset and randomized traffic against an arithmetic model.
module tb_cla_adder_pipe;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_sub = 1'b0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;

  int   errors = 0;
  int   checks = 0;
  int   n_acc = 0;
  int   n_out = 0;
  bit   rand_done = 1'b0;
  exp_t sb_q[$];

  cla_adder_pipe #(.WIDTH(32), .GROUPSIZE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input logic z);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.zero = z;
    return e;
  endfunction

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic cin);
    exp_t   e;
    longint ua, ub, sa, sb, r_u, r_s;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r_u    = ua - ub;
      r_s    = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      r_u    = ua + ub + longint'(cin);
      r_s    = sa + sb + longint'(cin);
      e.cout = (r_u >= 64'sd4294967296);
    end
    e.sum  = r_u[31:0];
    e.ovf  = (r_s > 64'sd2147483647) || (r_s < -64'sd2147483648);
    e.zero = (e.sum == 32'd0);
    return e;
  endfunction

  // Caller is just past a rising edge; returns just past the capturing edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic sub, input logic cin, input exp_t e);
    bit accepted;
    accepted = 1'b0;
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_q.push_back(e);
        n_acc++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      if (accepted) break;
    end
    if (!accepted) chk(1'b0, "accept_timeout", $sformatf("a=%h b=%h never accepted", a, b));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on each output transfer, checks hold during stalls.
  initial begin : monitor
    exp_t got, held, e;
    bit   prev_stall;
    prev_stall = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      got = mk(out_sum, out_cout, out_ovf, out_zero);
      if (rst_n === 1'b1 && out_valid === 1'b1 && !out_ready) begin
        if (prev_stall)
          chk(got == held, "stall_hold", $sformatf("got %h held %h", got, held));
        held = got;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready) begin
        if (sb_q.size() == 0) begin
          chk(1'b0, "unexpected_out", $sformatf("sum=%h with empty scoreboard", out_sum));
        end else begin
          e = sb_q.pop_front();
          chk(got == e, "result",
              $sformatf("got sum=%h c=%b o=%b z=%b need sum=%h c=%b o=%b z=%b",
                        got.sum, got.cout, got.ovf, got.zero, e.sum, e.cout, e.ovf, e.zero));
          $display("txn %0d sum=%h cout=%b ovf=%b zero=%b", n_out, got.sum, got.cout, got.ovf, got.zero);
        end
        n_out++;
      end
    end
  end

  initial begin : main
    int          acc0, out0;
    logic [31:0] a, b;
    logic        sub, cin;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk(out_valid == 1'b0 && out_sum == 32'd0 && !out_cout && !out_ovf && !out_zero,
        "reset_state", $sformatf("valid=%b sum=%h", out_valid, out_sum));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk(in_ready == 1'b1, "ready_after_reset", $sformatf("in_ready=%b need 1", in_ready));

    // Simple add plus latency: out_valid rises two edges after presentation.
    send(32'h1, 32'h1, 1'b0, 1'b0, mk(32'h2, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b0;
    @(negedge clk);
    chk(out_valid == 1'b0, "latency_early", $sformatf("out_valid=%b need 0", out_valid));
    @(posedge clk); #1;
    @(negedge clk);
    chk(out_valid == 1'b1, "latency_2", $sformatf("out_valid=%b need 1", out_valid));
    @(posedge clk); #1;
    idle(2);

    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1));
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    send(32'h8000_0000, 32'h1, 1'b1, 1'b0, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
    idle(4);

    // Backpressure: four back-to-back ops against a stalled consumer.
    out_ready = 1'b0;
    acc0 = n_acc;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          a = 32'h1000_0000 * (i + 1);
          b = 32'h0000_0111 * (i + 3);
          send(a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0));
        end
        in_valid = 1'b0;
      end
    join_none
    repeat (4) @(posedge clk);
    #1;
    chk(n_acc - acc0 == 2, "bp_accepts", $sformatf("accepted %0d need 2", n_acc - acc0));
    chk(in_ready == 1'b0, "bp_in_ready", $sformatf("in_ready=%b need 0", in_ready));
    out_ready = 1'b1;
    out0 = n_out;
    repeat (4) @(posedge clk);
    #1;
    chk(n_out - out0 == 4, "bp_drain_rate", $sformatf("%0d results in 4 cycles need 4", n_out - out0));
    wait fork;
    idle(3);

    // Reset with two ops in flight.
    out_ready = 1'b0;
    send(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b0, model(32'hAA, 32'h55, 1'b0, 1'b0));
    send(32'h0000_0F00, 32'h0000_000F, 1'b0, 1'b0, model(32'hF00, 32'hF, 1'b0, 1'b0));
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0 && out_sum == 32'd0 && !out_cout && !out_ovf && !out_zero,
        "async_reset", $sformatf("valid=%b sum=%h need 0/0", out_valid, out_sum));
    sb_q.delete();
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk(out_valid == 1'b0, "no_stale", $sformatf("out_valid=%b need 0 cycle %0d", out_valid, i));
    end
    @(posedge clk); #1;

    // Randomized traffic with random consumer stalls.
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 9) < 7);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin b = $urandom; a = ~b; end
        2: begin a = $urandom; b = a; end
        default: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
      endcase
      sub = $urandom_range(0, 1);
      cin = $urandom_range(0, 1);
      send(a, b, sub, cin, model(a, b, sub, cin));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    in_valid = 1'b0;
    rand_done = 1'b1;
    wait fork;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && sb_q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk(sb_q.size() == 0, "drain", $sformatf("%0d results outstanding need 0", sb_q.size()));
    chk(out_valid == 1'b0, "idle_valid", $sformatf("out_valid=%b need 0", out_valid));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
